id_ex_pipe: RTL

ID_EX_PIPE -- requirements
Module: id_ex_pipe

---
 rtl/id_ex_pipe.sv | 138 +++++++++++++
 1 files changed

// File: rtl/id_ex_pipe.sv
// rtl/id_ex_pipe.sv - ID/EX pipeline register with jump bubbles, hold stalls and optional bubble counter
//
// Purpose: registers the decoded instruction and its operands from id into ex.
// Each edge performs one action, highest priority first: reset, jump,
// jump-drain, hold, capture. Jump, drain, hold and reset load a NOP bubble.
// Optional feature macro: IDEX_PERF_CNT_EN (bubble counter on bubble_cnt_o).
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   hold_flag_i[2:0]           hold code from ctrl (>= 3'b011 stalls this stage)
//   hold_jump_i[2:0]           nonzero = jump taken this cycle
//   inst_i, inst_addr_i        instruction and PC from id
//   reg_we_i, reg_waddr_i      rd write enable and index from id
//   reg1_rdata_i, reg2_rdata_i source operands from id
//   inst_o .. reg2_rdata_o     registered copies to ex
//   inst_valid_o               1 = real instruction, 0 = bubble
//   bubble_cnt_o[31:0]         bubbles inserted since reset (0 when counter disabled)

module id_ex_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  hold_flag_i,
    input  logic [2:0]  hold_jump_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] inst_addr_i,
    input  logic        reg_we_i,
    input  logic [4:0]  reg_waddr_i,
    input  logic [31:0] reg1_rdata_i,
    input  logic [31:0] reg2_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        reg_we_o,
    output logic [4:0]  reg_waddr_o,
    output logic [31:0] reg1_rdata_o,
    output logic [31:0] reg2_rdata_o,
    output logic        inst_valid_o,
    output logic [31:0] bubble_cnt_o
);

    localparam logic [31:0] INST_NOP = 32'h00000013;
    localparam logic [2:0]  HOLD_ID  = 3'b011;

    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_addr_q, inst_addr_d;
    logic        reg_we_q, reg_we_d;
    logic [4:0]  reg_waddr_q, reg_waddr_d;
    logic [31:0] reg1_rdata_q, reg1_rdata_d;
    logic [31:0] reg2_rdata_q, reg2_rdata_d;
    logic        inst_valid_q, inst_valid_d;
    logic [1:0]  jcnt_q, jcnt_d;
    logic        bubble;

    always_comb begin
        jcnt_d = jcnt_q;
        bubble = 1'b0;
        if (hold_jump_i != 3'b000) begin
            // A new jump always restarts the drain window at 2, never accumulates.
            jcnt_d = 2'd2;
            bubble = 1'b1;
        end else if (jcnt_q != 2'd0) begin
            jcnt_d = jcnt_q - 2'd1;
            bubble = 1'b1;
        end else if (hold_flag_i >= HOLD_ID) begin
            // Codes above Hold_Id also stall here.
            bubble = 1'b1;
        end

        if (bubble) begin
            inst_d       = INST_NOP;
            inst_addr_d  = 32'd0;
            reg_we_d     = 1'b0;
            reg_waddr_d  = 5'd0;
            reg1_rdata_d = 32'd0;
            reg2_rdata_d = 32'd0;
            inst_valid_d = 1'b0;
        end else begin
            inst_d       = inst_i;
            inst_addr_d  = inst_addr_i;
            reg_we_d     = reg_we_i;
            reg_waddr_d  = reg_waddr_i;
            reg1_rdata_d = reg1_rdata_i;
            reg2_rdata_d = reg2_rdata_i;
            inst_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inst_q       <= INST_NOP;
            inst_addr_q  <= 32'd0;
            reg_we_q     <= 1'b0;
            reg_waddr_q  <= 5'd0;
            reg1_rdata_q <= 32'd0;
            reg2_rdata_q <= 32'd0;
            inst_valid_q <= 1'b0;
            jcnt_q       <= 2'd0;
        end else begin
            inst_q       <= inst_d;
            inst_addr_q  <= inst_addr_d;
            reg_we_q     <= reg_we_d;
            reg_waddr_q  <= reg_waddr_d;
            reg1_rdata_q <= reg1_rdata_d;
            reg2_rdata_q <= reg2_rdata_d;
            inst_valid_q <= inst_valid_d;
            jcnt_q       <= jcnt_d;
        end
    end

    assign inst_o       = inst_q;
    assign inst_addr_o  = inst_addr_q;
    assign reg_we_o     = reg_we_q;
    assign reg_waddr_o  = reg_waddr_q;
    assign reg1_rdata_o = reg1_rdata_q;
    assign reg2_rdata_o = reg2_rdata_q;
    assign inst_valid_o = inst_valid_q;

`ifdef IDEX_PERF_CNT_EN
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    // Counts every non-reset bubble edge; wraps naturally at 32 bits.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q + {31'd0, bubble};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_q <= 32'd0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt_o = bubble_cnt_q;
`else
    assign bubble_cnt_o = 32'd0;
`endif

endmodule
